masked_array_ext: RTL and testbench



---
 rtl/masked_array_ext_pkg.sv | 13 +
 rtl/masked_array_core.sv | 44 ++++
 rtl/masked_array_ext.sv | 136 +++++++++++++
 tb/tb_masked_array_ext.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_array_ext_pkg.sv
// Shared types and helpers for the masked single-port array and its storage core.
package masked_array_ext_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic int calc_data_w(input int mask_w, input int gran);
        return mask_w * gran;
    endfunction

endpackage

// File: rtl/masked_array_core.sv
// 1RW storage with per-lane write enables and a synchronous, resettable read register.
// Each lane is its own narrow array so it maps onto block RAM or a vendor macro.
module masked_array_core #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int MASK_W = 16,
    parameter int GRAN   = 7
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     we,
    input  logic [MASK_W-1:0]        wmask,
    input  logic [MASK_W*GRAN-1:0]   wdata,
    input  logic                     re,
    output logic [MASK_W*GRAN-1:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < MASK_W; gi++) begin : g_lane
            logic [GRAN-1:0] lane_mem [DEPTH];
            logic [GRAN-1:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (we && wmask[gi]) begin
                    lane_mem[addr] <= wdata[gi*GRAN +: GRAN];
                end
            end

            // Read register only moves on a read, so it holds across later writes.
            always_ff @(posedge clk) begin
                if (srst) begin
                    rdata_reg <= '0;
                end else if (re) begin
                    rdata_reg <= lane_mem[addr];
                end
            end

            assign rdata[gi*GRAN +: GRAN] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/masked_array_ext.sv
// Masked 1RW array wrapper: zero-fill sweep FSM, range checking, error pulse
// and a 1- or 2-cycle read pipeline around masked_array_core.
module masked_array_ext
    import masked_array_ext_pkg::*;
#(
    parameter int  DEPTH     = 4096,
    parameter int  ADDR_W    = 12,
    parameter int  MASK_W    = 16,
    parameter int  GRAN      = 7,
    parameter int  RD_LAT    = 1,
    parameter int  INIT_ZERO = 1,
    localparam int DATA_W    = calc_data_w(MASK_W, GRAN)
) (
    input  logic              RW0_clk,
    input  logic              RW0_rst_n,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [MASK_W-1:0] RW0_wmask,
    input  logic [DATA_W-1:0] RW0_wdata,
    output logic [DATA_W-1:0] RW0_rdata,
    output logic              RW0_rvalid,
    output logic              RW0_ready,
    output logic              RW0_err
);

    localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_W    = (ADDR_W+1)'(DEPTH - 1);
    localparam state_t          RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_READY;

    if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
        $error("masked_array_ext: ADDR_W too narrow for DEPTH");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("masked_array_ext: RD_LAT must be 1 or 2");
    end

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   cnt_reg, cnt_next;
    logic              err_reg;
    logic              rv1_reg;
    logic              ready;
    logic              in_range;
    logic              accept;
    logic              rd_en;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [MASK_W-1:0] core_mask;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;

    assign ready     = (state_reg == ST_READY);
    assign in_range  = ({1'b0, RW0_addr} < DEPTH_W);
    assign accept    = RW0_rst_n && RW0_en && ready && in_range;
    assign rd_en     = accept && !RW0_wmode;
    assign RW0_ready = ready;
    assign RW0_err   = err_reg;

    // During the sweep the core port belongs to the counter; user requests are rejected.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        core_we    = 1'b0;
        core_addr  = RW0_addr;
        core_mask  = RW0_wmask;
        core_wdata = RW0_wdata;
        if (state_reg == ST_INIT) begin
            cnt_next   = cnt_reg + 1'b1;
            core_we    = RW0_rst_n;
            core_addr  = cnt_reg[ADDR_W-1:0];
            core_mask  = '1;
            core_wdata = '0;
            if (cnt_reg == LAST_W) begin
                state_next = ST_READY;
            end
        end else begin
            core_we = accept && RW0_wmode;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (!RW0_rst_n) begin
            state_reg <= RST_STATE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            rv1_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= RW0_en && !(ready && in_range);
            rv1_reg   <= rd_en;
        end
    end

    masked_array_core #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .MASK_W (MASK_W),
        .GRAN   (GRAN)
    ) u_core (
        .clk   (RW0_clk),
        .srst  (!RW0_rst_n),
        .addr  (core_addr),
        .we    (core_we),
        .wmask (core_mask),
        .wdata (core_wdata),
        .re    (rd_en),
        .rdata (core_rdata)
    );

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              rv2_reg;
            logic [DATA_W-1:0] rdata2_reg;

            always_ff @(posedge RW0_clk) begin
                if (!RW0_rst_n) begin
                    rv2_reg    <= 1'b0;
                    rdata2_reg <= '0;
                end else begin
                    rv2_reg <= rv1_reg;
                    if (rv1_reg) begin
                        rdata2_reg <= core_rdata;
                    end
                end
            end

            assign RW0_rvalid = rv2_reg;
            assign RW0_rdata  = rdata2_reg;
        end else begin : g_lat1
            assign RW0_rvalid = rv1_reg;
            assign RW0_rdata  = core_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_masked_array_ext.sv
// Self-checking bench: instance 0 is DEPTH=4096/RD_LAT=1, instance 1 is DEPTH=3000/RD_LAT=2.
module tb_masked_array_ext;

    localparam int AW = 12;
    localparam int MW = 16;
    localparam int GR = 7;
    localparam int DW = MW * GR;

    logic RW0_clk = 1'b0;
    always #5 RW0_clk = ~RW0_clk;

    logic          rst_n  [2];
    logic          en     [2];
    logic          wmode  [2];
    logic [AW-1:0] addr   [2];
    logic [MW-1:0] wmask  [2];
    logic [DW-1:0] wdata  [2];
    logic [DW-1:0] rdata  [2];
    logic          rvalid [2];
    logic          ready  [2];
    logic          err    [2];

    logic [DW-1:0] model   [2][4096];
    logic [DW-1:0] last_rd [2];
    int n_cmp = 0;
    int n_bad = 0;

    masked_array_ext #(.DEPTH(4096), .ADDR_W(AW), .MASK_W(MW), .GRAN(GR), .RD_LAT(1), .INIT_ZERO(1)) u_dut_a (
        .RW0_clk(RW0_clk), .RW0_rst_n(rst_n[0]), .RW0_addr(addr[0]), .RW0_en(en[0]),
        .RW0_wmode(wmode[0]), .RW0_wmask(wmask[0]), .RW0_wdata(wdata[0]), .RW0_rdata(rdata[0]),
        .RW0_rvalid(rvalid[0]), .RW0_ready(ready[0]), .RW0_err(err[0])
    );

    masked_array_ext #(.DEPTH(3000), .ADDR_W(AW), .MASK_W(MW), .GRAN(GR), .RD_LAT(2), .INIT_ZERO(1)) u_dut_b (
        .RW0_clk(RW0_clk), .RW0_rst_n(rst_n[1]), .RW0_addr(addr[1]), .RW0_en(en[1]),
        .RW0_wmode(wmode[1]), .RW0_wmask(wmask[1]), .RW0_wdata(wdata[1]), .RW0_rdata(rdata[1]),
        .RW0_rvalid(rvalid[1]), .RW0_ready(ready[1]), .RW0_err(err[1])
    );

    function automatic int depth_of(input int d);
        return (d == 0) ? 4096 : 3000;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [MW-1:0] m,
                                            input logic [DW-1:0] wd);
        logic [DW-1:0] res;
        res = old;
        for (int i = 0; i < MW; i++) begin
            if (m[i]) res[i*GR +: GR] = wd[i*GR +: GR];
        end
        return res;
    endfunction

    task automatic drive(input int d, input logic e, input logic w, input logic [AW-1:0] a,
                         input logic [MW-1:0] m, input logic [DW-1:0] wd);
        en[d] = e; wmode[d] = w; addr[d] = a; wmask[d] = m; wdata[d] = wd;
        if (e) $display("[%0t] dut%0d %s addr=%0d mask=%h", $time, d, w ? "WR" : "RD", a, m);
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Reference behaviour of an accepted request (target is READY).
    task automatic model_apply(input int d, input logic e, input logic w, input logic [AW-1:0] a,
                               input logic [MW-1:0] m, input logic [DW-1:0] wd);
        if (e && w && int'(a) < depth_of(d)) model[d][a] = merge(model[d][a], m, wd);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin rst_n[d] = 1'b0; idle(d); end
        repeat (3) @(negedge RW0_clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (rvalid[d] !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid dut%0d: got %b want 0", d, rvalid[d]); end
            n_cmp++; if (err[d] !== 1'b0) begin n_bad++; $display("FAIL reset_err dut%0d: got %b want 0", d, err[d]); end
            n_cmp++; if (rdata[d] !== '0) begin n_bad++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata[d]); end
            n_cmp++; if (ready[d] !== 1'b0) begin n_bad++; $display("FAIL reset_ready dut%0d: got %b want 0", d, ready[d]); end
            last_rd[d] = '0;
        end
    endtask

    // Pulse reset, then the sweep must take exactly DEPTH cycles.
    task automatic test_init_sweep(input int d);
        int depth;
        depth = depth_of(d);
        rst_n[d] = 1'b0; idle(d);
        @(negedge RW0_clk);
        rst_n[d] = 1'b1;
        for (int k = 1; k <= depth; k++) begin
            @(negedge RW0_clk);
            if (k == depth - 1) begin
                n_cmp++; if (ready[d] !== 1'b0) begin n_bad++; $display("FAIL sweep_early dut%0d k=%0d: got %b want 0", d, k, ready[d]); end
            end
            if (k == depth) begin
                n_cmp++; if (ready[d] !== 1'b1) begin n_bad++; $display("FAIL sweep_done dut%0d k=%0d: got %b want 1", d, k, ready[d]); end
            end
        end
        for (int i = 0; i < 4096; i++) model[d][i] = '0;
        last_rd[d] = '0;
    endtask

    task automatic test_init_restart();
        rst_n[0] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 50) drive(0, 1'b1, 1'b1, 12'd9, '1, rnd_word()); else idle(0);
            @(negedge RW0_clk);
            if (k == 50) begin
                n_cmp++; if (err[0] !== 1'b1) begin n_bad++; $display("FAIL init_req_err: got %b want 1", err[0]); end
            end
            if (k == 51) begin
                n_cmp++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL init_err_pulse: got %b want 0", err[0]); end
            end
            if (k == 100) begin
                n_cmp++; if (ready[0] !== 1'b0) begin n_bad++; $display("FAIL init_ready_mid: got %b want 0", ready[0]); end
            end
        end
        test_init_sweep(0);
    endtask

    task automatic test_init_reads(input int d);
        int addrs [4];
        addrs = '{0, 1234, depth_of(d) - 1, 9};
        for (int i = 0; i < 4; i++) begin
            drive(d, 1'b1, 1'b0, AW'(addrs[i]), '0, '0);
            @(negedge RW0_clk);
            idle(d);
            if (lat_of(d) == 2) @(negedge RW0_clk);
            n_cmp++; if (rvalid[d] !== 1'b1) begin n_bad++; $display("FAIL init_read_rv dut%0d addr=%0d: got %b want 1", d, addrs[i], rvalid[d]); end
            n_cmp++; if (rdata[d] !== '0) begin n_bad++; $display("FAIL init_read_zero dut%0d addr=%0d: got %h want 0", d, addrs[i], rdata[d]); end
        end
        @(negedge RW0_clk);
    endtask

    task automatic test_reset_midread(input int d);
        logic [DW-1:0] v;
        v = rnd_word();
        drive(d, 1'b1, 1'b1, 12'd20, '1, v);
        @(negedge RW0_clk);
        drive(d, 1'b1, 1'b0, 12'd20, '0, '0);
        @(negedge RW0_clk);
        rst_n[d] = 1'b0; idle(d);
        @(negedge RW0_clk);
        n_cmp++; if (rdata[d] !== '0) begin n_bad++; $display("FAIL midread_rdata dut%0d: got %h want 0", d, rdata[d]); end
        rst_n[d] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            n_cmp++; if (rvalid[d] !== 1'b0) begin n_bad++; $display("FAIL midread_flush dut%0d j=%0d: got %b want 0", d, j, rvalid[d]); end
            @(negedge RW0_clk);
        end
        n_cmp++; if (ready[d] !== 1'b0) begin n_bad++; $display("FAIL midread_ready dut%0d: got %b want 0", d, ready[d]); end
    endtask

    task automatic test_lane_mask(input int d);
        int L;
        logic [DW-1:0] ones;
        logic [DW-1:0] exp7f;
        L = lat_of(d);
        ones = '1;
        exp7f = DW'(7'h7F);
        for (int j = 1; j <= 5; j++) begin
            case (j)
                1: begin drive(d, 1'b1, 1'b1, 12'd5, 16'h0001, ones); model_apply(d, 1'b1, 1'b1, 12'd5, 16'h0001, ones); end
                2: drive(d, 1'b1, 1'b1, 12'd5, 16'h0000, rnd_word());
                3: drive(d, 1'b1, 1'b0, 12'd5, '0, '0);
                default: idle(d);
            endcase
            @(negedge RW0_clk);
            if (j >= 2 + L) last_rd[d] = exp7f;
            n_cmp++; if (err[d] !== 1'b0) begin n_bad++; $display("FAIL mask_err dut%0d j=%0d: got %b want 0", d, j, err[d]); end
            n_cmp++; if (rvalid[d] !== (j == 2 + L)) begin n_bad++; $display("FAIL mask_rvalid dut%0d j=%0d: got %b want %b", d, j, rvalid[d], j == 2 + L); end
            n_cmp++; if (rdata[d] !== last_rd[d]) begin n_bad++; $display("FAIL mask_rdata dut%0d j=%0d: got %h want %h", d, j, rdata[d], last_rd[d]); end
        end
    endtask

    task automatic test_read_before_write(input int d);
        int L;
        logic [DW-1:0] v1, v2, want;
        L = lat_of(d);
        v1 = rnd_word();
        v2 = ~v1;
        drive(d, 1'b1, 1'b1, 12'd7, '1, v1);
        @(negedge RW0_clk);
        for (int j = 1; j <= 6; j++) begin
            case (j)
                1: drive(d, 1'b1, 1'b0, 12'd7, '0, '0);
                2: drive(d, 1'b1, 1'b1, 12'd7, '1, v2);
                4: drive(d, 1'b1, 1'b0, 12'd7, '0, '0);
                default: idle(d);
            endcase
            @(negedge RW0_clk);
            want = (j >= 3 + L) ? v2 : (j >= L) ? v1 : last_rd[d];
            n_cmp++; if (rvalid[d] !== (j == L || j == 3 + L)) begin n_bad++; $display("FAIL rbw_rvalid dut%0d j=%0d: got %b", d, j, rvalid[d]); end
            n_cmp++; if (rdata[d] !== want) begin n_bad++; $display("FAIL rbw_rdata dut%0d j=%0d: got %h want %h", d, j, rdata[d], want); end
        end
        model[d][7] = v2;
        last_rd[d] = v2;
    endtask

    task automatic test_range(input int d);
        int L;
        logic [DW-1:0] v1, want;
        L = lat_of(d);
        v1 = rnd_word();
        drive(d, 1'b1, 1'b1, 12'd2999, '1, v1);
        model_apply(d, 1'b1, 1'b1, 12'd2999, '1, v1);
        @(negedge RW0_clk);
        for (int j = 1; j <= 6; j++) begin
            case (j)
                1: drive(d, 1'b1, 1'b1, 12'd3000, '1, rnd_word());
                2: drive(d, 1'b1, 1'b0, 12'd3000, '0, '0);
                3: drive(d, 1'b1, 1'b1, 12'd4095, '1, rnd_word());
                4: drive(d, 1'b1, 1'b0, 12'd2999, '0, '0);
                default: idle(d);
            endcase
            @(negedge RW0_clk);
            want = (j >= 3 + L) ? v1 : last_rd[d];
            n_cmp++; if (err[d] !== (j <= 3)) begin n_bad++; $display("FAIL range_err dut%0d j=%0d: got %b want %b", d, j, err[d], j <= 3); end
            n_cmp++; if (rvalid[d] !== (j == 3 + L)) begin n_bad++; $display("FAIL range_rvalid dut%0d j=%0d: got %b", d, j, rvalid[d]); end
            n_cmp++; if (rdata[d] !== want) begin n_bad++; $display("FAIL range_rdata dut%0d j=%0d: got %h want %h", d, j, rdata[d], want); end
        end
        last_rd[d] = v1;
    endtask

    // Back-to-back random traffic; expected read results queued by latency.
    task automatic test_random(input int d, input int n);
        int L;
        logic exp_rv_q [$];
        logic [DW-1:0] exp_d_q [$];
        L = lat_of(d);
        for (int i = 1; i < L; i++) begin exp_rv_q.push_back(1'b0); exp_d_q.push_back('0); end
        for (int c = 0; c < n + L - 1; c++) begin
            logic e, w, rv_e, err_e, hit;
            logic [AW-1:0] a;
            logic [MW-1:0] m;
            logic [DW-1:0] wd, d_e;
            e = (c < n) && ($urandom_range(0, 9) != 0);
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = AW'($urandom_range(0, 4095));
                1: a = (d == 1) ? AW'($urandom_range(2996, 3003)) : AW'($urandom_range(4088, 4095));
                default: a = AW'($urandom_range(0, 7));
            endcase
            m = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom());
            wd = rnd_word();
            if (e) drive(d, e, w, a, m, wd); else idle(d);
            hit = int'(a) < depth_of(d);
            err_e = e && !hit;
            exp_rv_q.push_back(e && !w && hit);
            exp_d_q.push_back(hit ? model[d][a] : '0);
            model_apply(d, e, w, a, m, wd);
            @(negedge RW0_clk);
            rv_e = exp_rv_q.pop_front();
            d_e = exp_d_q.pop_front();
            if (rv_e) last_rd[d] = d_e;
            n_cmp++; if (err[d] !== err_e) begin n_bad++; $display("FAIL rand_err dut%0d c=%0d: got %b want %b", d, c, err[d], err_e); end
            n_cmp++; if (rvalid[d] !== rv_e) begin n_bad++; $display("FAIL rand_rvalid dut%0d c=%0d: got %b want %b", d, c, rvalid[d], rv_e); end
            n_cmp++; if (rdata[d] !== last_rd[d]) begin n_bad++; $display("FAIL rand_rdata dut%0d c=%0d: got %h want %h", d, c, rdata[d], last_rd[d]); end
        end
        idle(d);
    endtask

    initial begin
        test_reset();
        test_init_restart();
        test_init_reads(0);
        test_init_sweep(1);
        test_init_reads(1);
        test_reset_midread(1);
        test_init_sweep(1);
        test_lane_mask(0);
        test_lane_mask(1);
        test_read_before_write(0);
        test_read_before_write(1);
        test_range(1);
        test_random(0, 300);
        test_random(1, 300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
